// File: rtl/axis_packet_capture.sv
// axis_packet_capture: AXI-Stream sink capturing beats into a buffer, counting beats/packets,
// with start-toggled capture, full/overflow handling and a scanned count display.
module axis_packet_capture #(
  parameter int DATA_W   = 256,
  parameter int DEPTH    = 4096,
  parameter int CNT_W    = 32,
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 100000,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              resent_i,
  input  logic              start_i,
  input  logic              clear_i,
  input  logic              mode_i,
  input  logic              disp_sel_i,
  input  logic [DATA_W-1:0] tdata_i,
  input  logic              tvalid_i,
  input  logic              tlast_i,
  output logic              tready_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [CNT_W-1:0]  pkt_count_o,
  output logic [CNT_W-1:0]  beat_count_o,
  output logic              overflow_o,
  output logic [31:0]       sevenseg_o,
  output logic [7:0]        digital_enable_o
);
  typedef enum logic [1:0] {IDLE, RUN, FULL, DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [31:0] SCAN_LAST = 32'(SCAN_DIV - 1);
  localparam logic [7:0] LAST_EN = 8'(1) << (DIGITS - 1);
  state_t state_q, state_d;
  logic start_q, tready_q, overflow_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] pkt_q, beat_q;
  logic [31:0] sevenseg_q, scan_q;
  logic [7:0] en_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic rise, acc;
  assign rise = start_i & ~start_q;
  assign acc  = tvalid_i & tready_q;
  // A start edge in RUN wins over the full/done exits; the beat on that edge is still taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = rise ? RUN : IDLE;
      RUN:     state_d = rise ? IDLE
                       : (acc && wr_ptr_q == LAST_PTR) ? FULL
                       : (acc && tlast_i && mode_i) ? DONE : RUN;
      default: state_d = rise ? RUN : state_q;
    endcase
    if (clear_i) state_d = IDLE;
  end
  always_ff @(posedge clk_i or posedge resent_i) begin
    if (resent_i) begin
      state_q    <= IDLE;
      tready_q   <= 1'b0;
      start_q    <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      pkt_q      <= '0;
      beat_q     <= '0;
      sevenseg_q <= '0;
      rd_data_q  <= '0;
      scan_q     <= '0;
      en_q       <= 8'd1;
    end else begin
      state_q    <= state_d;
      tready_q   <= state_d == RUN;
      start_q    <= start_i;
      overflow_q <= !clear_i && (overflow_q || (state_q == FULL && tvalid_i));
      wr_ptr_q   <= clear_i ? '0 : wr_ptr_q + ADDR_W'(acc);
      beat_q     <= clear_i ? '0 : beat_q + CNT_W'(acc);
      pkt_q      <= clear_i ? '0 : pkt_q + CNT_W'(acc & tlast_i);
      sevenseg_q <= disp_sel_i ? 32'(beat_q) : 32'(pkt_q);
      rd_data_q  <= mem[rd_addr_i];
      scan_q     <= scan_q == SCAN_LAST ? '0 : scan_q + 32'd1;
      en_q       <= scan_q != SCAN_LAST ? en_q : en_q == LAST_EN ? 8'd1 : en_q << 1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (acc && !clear_i) mem[wr_ptr_q] <= tdata_i;
  end
  assign tready_o         = tready_q;
  assign rd_data_o        = rd_data_q;
  assign pkt_count_o      = pkt_q;
  assign beat_count_o     = beat_q;
  assign overflow_o       = overflow_q;
  assign sevenseg_o       = sevenseg_q;
  assign digital_enable_o = en_q;
endmodule

// File: tb/tb_axis_packet_capture.sv
// tb_axis_packet_capture: directed checks of capture, mode, full/overflow, clear, reset and display scan.
module tb_axis_packet_capture;
  localparam int DATA_W = 16, DEPTH = 16, CNT_W = 16, DIGITS = 4, SCAN_DIV = 2;
  logic clk = 0, resent, start, clear, mode, disp_sel, tvalid, tlast, tready, overflow;
  logic [DATA_W-1:0] tdata, rd_data;
  logic [3:0] rd_addr;
  logic [CNT_W-1:0] pkt_count, beat_count;
  logic [31:0] sevenseg;
  logic [7:0] digital_enable;
  int n_chk = 0, n_fail = 0;
  axis_packet_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .DIGITS(DIGITS),
                        .SCAN_DIV(SCAN_DIV)) dut (
    .clk_i(clk), .resent_i(resent), .start_i(start), .clear_i(clear), .mode_i(mode),
    .disp_sel_i(disp_sel), .tdata_i(tdata), .tvalid_i(tvalid), .tlast_i(tlast),
    .tready_o(tready), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .pkt_count_o(pkt_count),
    .beat_count_o(beat_count), .overflow_o(overflow), .sevenseg_o(sevenseg),
    .digital_enable_o(digital_enable));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    start = 1;
    step();
    start = 0;
  endtask
  logic [7:0] scan_exp [9] = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h04, 8'h04, 8'h08, 8'h08, 8'h01};
  initial begin
    resent = 1; start = 0; clear = 0; mode = 0; disp_sel = 0;
    tvalid = 0; tlast = 0; tdata = 0; rd_addr = 0;
    #12;
    chk("rst_tready", 32'(tready), 0);
    chk("rst_pkt", 32'(pkt_count), 0);
    chk("rst_beat", 32'(beat_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_7seg", sevenseg, 0);
    chk("rst_en", 32'(digital_enable), 1);
    chk("rst_rd", 32'(rd_data), 0);
    @(negedge clk) resent = 0;
    chk("scan0", 32'(digital_enable), 32'(scan_exp[0]));
    for (int i = 1; i < 9; i++) begin
      step();
      chk($sformatf("scan%0d", i), 32'(digital_enable), 32'(scan_exp[i]));
    end
    // three 4-beat packets in continuous mode
    pulse_start();
    chk("arm_tready", 32'(tready), 1);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("run_tready%0d", i), 32'(tready), 1);
      tvalid = 1; tdata = 16'(i); tlast = (i % 4 == 3);
      step();
    end
    tvalid = 0; tlast = 0;
    chk("p3_pkt", 32'(pkt_count), 3);
    chk("p3_beat", 32'(beat_count), 12);
    chk("p3_7seg_lag", sevenseg, 2);
    step();
    chk("p3_7seg_pkt", sevenseg, 3);
    disp_sel = 1;
    step();
    chk("p3_7seg_beat", sevenseg, 12);
    disp_sel = 0;
    step();
    chk("p3_7seg_back", sevenseg, 3);
    for (int i = 0; i < 12; i++) begin
      rd_addr = 4'(i);
      step();
      chk($sformatf("buf%0d", i), 32'(rd_data), i);
    end
    // clear wins over a simultaneous beat
    clear = 1; tvalid = 1; tdata = 16'd99;
    step();
    clear = 0; tvalid = 0;
    chk("clr_pkt", 32'(pkt_count), 0);
    chk("clr_beat", 32'(beat_count), 0);
    chk("clr_tready", 32'(tready), 0);
    rd_addr = 0;
    step();
    chk("clr_buf0", 32'(rd_data), 0);
    // single-packet mode: second packet is refused
    mode = 1;
    pulse_start();
    chk("m1_tready", 32'(tready), 1);
    for (int j = 0; j < 6; j++) begin
      tvalid = 1; tdata = 16'(100 + j); tlast = (j % 3 == 2);
      step();
      if (j == 2) chk("m1_done_tready", 32'(tready), 0);
    end
    tvalid = 0; tlast = 0; mode = 0;
    chk("m1_pkt", 32'(pkt_count), 1);
    chk("m1_beat", 32'(beat_count), 3);
    rd_addr = 2;
    step();
    chk("m1_buf2", 32'(rd_data), 102);
    // DONE -> RUN, then a start edge together with an accepted beat
    pulse_start();
    chk("resume_tready", 32'(tready), 1);
    step();
    start = 1; tvalid = 1; tdata = 16'd7;
    step();
    start = 0;
    chk("edge_acc_beat", 32'(beat_count), 4);
    chk("edge_acc_tready", 32'(tready), 0);
    step();
    tvalid = 0;
    chk("idle_hold_beat", 32'(beat_count), 4);
    // fill the buffer, overflow, then wrap
    clear = 1;
    step();
    clear = 0;
    pulse_start();
    for (int i = 0; i < DEPTH; i++) begin
      tvalid = 1; tdata = 16'(200 + i);
      step();
    end
    chk("full_tready", 32'(tready), 0);
    chk("full_beat", 32'(beat_count), 16);
    chk("full_ovf0", 32'(overflow), 0);
    step();
    tvalid = 0;
    chk("full_ovf1", 32'(overflow), 1);
    chk("full_hold_beat", 32'(beat_count), 16);
    rd_addr = 15;
    step();
    chk("full_buf15", 32'(rd_data), 215);
    rd_addr = 1;
    pulse_start();
    chk("refill_tready", 32'(tready), 1);
    chk("refill_buf1", 32'(rd_data), 201);
    rd_addr = 0; tvalid = 1; tdata = 16'h5a5a;
    step();
    tvalid = 0;
    chk("rdw_old", 32'(rd_data), 200);
    chk("wrap_beat", 32'(beat_count), 17);
    step();
    chk("wrap_buf0", 32'(rd_data), 16'h5a5a);
    chk("wrap_ovf_sticky", 32'(overflow), 1);
    // asynchronous reset mid-packet
    for (int i = 0; i < 2; i++) begin
      tvalid = 1; tdata = 16'(i);
      step();
    end
    chk("mid_beat", 32'(beat_count), 19);
    #2 resent = 1;
    #1;
    chk("arst_beat", 32'(beat_count), 0);
    chk("arst_pkt", 32'(pkt_count), 0);
    chk("arst_ovf", 32'(overflow), 0);
    chk("arst_tready", 32'(tready), 0);
    chk("arst_7seg", sevenseg, 0);
    chk("arst_en", 32'(digital_enable), 1);
    chk("arst_rd", 32'(rd_data), 0);
    @(negedge clk) resent = 0;
    step();
    step();
    chk("post_rst_tready", 32'(tready), 0);
    chk("post_rst_beat", 32'(beat_count), 0);
    tvalid = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_packet_capture.md
# axis_packet_capture

AXI-Stream sink that captures incoming beats into an on-chip buffer, counts accepted beats and completed packets, and shows a selected count on the board's eight-digit seven-segment display. It replaces the fixed 256-bit, start-toggled packet counter. New in this block: parametrised width and depth, a synchronous start toggle, a defined full/overflow policy, a single-packet capture mode, buffer readback, and a scanned display. It sits at the end of an AXI-Stream source chain, in the board top level.

## Interface
- DATA_W, 256, tdata width in bits
- DEPTH, 4096, buffer entries; power of two, ≥2; ADDR_W = clog2(DEPTH)
- CNT_W, 32, beat/packet counter width; 1..32
- DIGITS, 8, number of active display digits; 1..8
- SCAN_DIV, 100000, clk cycles per display digit step; ≥1
- clk  in  1  system clock; all logic on rising edge
- resent  in  1  asynchronous, active-high reset
- start  in  1  arm/disarm request, level; the rising edge toggles capture
- clear  in  1  synchronous clear of counters, pointer and flags
- mode  in  1  0 = continuous capture; 1 = stop after first complete packet
- disp_sel  in  1  0 = display packet count; 1 = display beat count
- tdata  in  DATA_W  stream data
- tvalid  in  1  stream valid
- tlast  in  1  last beat of packet
- tready  out  1  registered ready
- rd_addr  in  ADDR_W  buffer readback address
- rd_data  out  DATA_W  buffer word at rd_addr, 1-cycle latency
- pkt_count  out  CNT_W  completed packets
- beat_count  out  CNT_W  accepted beats
- overflow  out  1  sticky: tvalid was seen while FULL
- sevenseg  out  32  selected count, zero-extended to 32 bits
- digital_enable  out  8  one-hot digit enable, active-high

## Operation
- Accept = tvalid & tready. Every accepted beat, including the tlast beat, is written to buffer[wr_ptr]; wr_ptr increments; beat_count increments. When tlast is set, pkt_count also increments.
- start is registered into start_q. edge = start & ~start_q.
- States:
  - IDLE: tready=0.
  - RUN: tready=1.
  - FULL: tready=0.
  - DONE: tready=0.
- Transitions:
  - IDLE + edge → RUN.
  - RUN + edge → IDLE. An edge takes priority over an accept in the same cycle; that beat is still accepted, because tready was 1.
  - RUN + accept with wr_ptr == DEPTH-1 → FULL. The beat is written to the last entry, and wr_ptr wraps to 0.
  - RUN + accept with tlast and mode=1 → DONE. If both full and DONE conditions hold, FULL wins.
  - FULL or DONE + edge → RUN. wr_ptr is not reset; capture continues from wr_ptr, which overwrites from 0 after FULL.
- tready is registered: tready = (next state == RUN).
- overflow: set in any cycle with state FULL and tvalid=1. Cleared only by clear or resent.
- Counters wrap modulo 2^CNT_W.
- clear: state → IDLE; wr_ptr, pkt_count, beat_count and overflow → 0; tready → 0. clear beats edge and accept in the same cycle. Buffer contents are unchanged.
- Display:
  - sevenseg = disp_sel ? beat_count : pkt_count, registered.
  - digital_enable rotates left one bit every SCAN_DIV cycles through bits 0..DIGITS-1, then back to bit 0. Bits at DIGITS and above are always 0.

## Timing
- Reset values (resent=1, asynchronous):
  - state=IDLE, tready=0, wr_ptr=0, start_q=0.
  - pkt_count=0, beat_count=0, overflow=0.
  - sevenseg=0, digital_enable=8'b00000001, rd_data=0, scan counter=0.
- Reset mid-packet: the partial packet is discarded from the counts; buffer contents are don't-care.
- start rises and is sampled at edge k → tready=1 after edge k. A beat can be accepted at edge k+1.
- Accept of the last entry at edge k → tready=0 after edge k. No beat is accepted at edge k+1.
- Counter outputs update at the same edge as the accept. sevenseg lags the counters by one cycle.
- rd_data reflects buffer[rd_addr] one edge after rd_addr is sampled. A read and a write to the same address in the same cycle return the old data.
- tvalid may be asserted while tready=0; no data is taken and the source holds.

## Test plan
- Reset, then start pulse, then 3 packets of 4 beats each, with tdata = beat index → pkt_count=3, beat_count=12, buffer[0..11]=0..11, tready=1 throughout.
- mode=1, start, then 2 packets of 3 beats back-to-back → pkt_count=1, beat_count=3, tready=0 from the cycle after the first tlast, state DONE.
- DEPTH=8, start, continuous tvalid with no tlast → 8 beats accepted, tready=0 after the 8th, overflow=1 on the next tvalid. A new start edge → tready=1, and the next beat lands in buffer[0].
- In RUN, start rises in the same cycle as an accepted beat → the beat is counted, then tready=0 (IDLE). clear together with tvalid → all counters 0 and state IDLE.
- Assert resent mid-packet after 2 beats → all outputs at reset values immediately, without a clk edge; after release, tready=0 until the next start edge.
- SCAN_DIV=2, DIGITS=4 → digital_enable sequence 01,01,02,02,04,04,08,08,01. disp_sel toggling → sevenseg switches between pkt_count and beat_count one cycle later.
